// File: rtl/reg_access_master_pkg.sv
// ---------------------------------------------------------------------------
// reg_access_master_pkg
// Shared constants for the register-file bus initiator: FSM state encoding,
// read-latency range, block-read length limit, write gap length, the board
// register address map and the command-length clamp helper.
// Optional feature macro used by the importing RTL: REG_BLOCK_READ_EN.
// ---------------------------------------------------------------------------
package reg_access_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_GAP     = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_t;

  // Responder read latency supported by the delay counter.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int LAT_CNT_W  = 2;  // holds RD_LAT_MAX-1

  // Default block-read limit in quadlets.
  localparam int MAX_LEN_DEF = 16;

  // Idle cycles after each write strobe so every write has its own rising
  // edge of reg_wen (the watchdog clears on that edge).
  localparam int GAP_CYCLES = 1;

  // Board register map (quadlet space).
  localparam logic [15:0] REG_ADDR_STATUS   = 16'h0000;
  localparam logic [15:0] REG_ADDR_PHYCTRL  = 16'h0001;
  localparam logic [15:0] REG_ADDR_PHYDATA  = 16'h0002;
  localparam logic [15:0] REG_ADDR_TIMEOUT  = 16'h0003;
  localparam logic [15:0] REG_ADDR_VERSION  = 16'h0004;
  localparam logic [15:0] REG_ADDR_TEMP     = 16'h0005;
  localparam logic [15:0] REG_ADDR_DIGIN    = 16'h0006;
  localparam logic [15:0] REG_ADDR_PROMSTAT = 16'h0008;

  // A requested length of 0 means one quadlet; anything above the limit
  // is cut to the limit.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0)            return 1;
    else if (len > max_len)  return max_len;
    else                     return len;
  endfunction

endpackage

// File: rtl/reg_access_master_rd_delay.sv
// ---------------------------------------------------------------------------
// reg_rd_delay
// Loadable down-counter that times the RD_WAIT state. Loading happens in the
// cycle the read address is first presented; o_done is high in the last
// RD_WAIT cycle, i.e. RD_LATENCY cycles after the load cycle ends.
// Ports:
//   clk     in  clock
//   rst_n   in  asynchronous active-low reset
//   i_load  in  restart the count (RD_ADDR state)
//   o_done  out capture strobe: register read data is valid this cycle
// ---------------------------------------------------------------------------
module reg_rd_delay
  import reg_access_master_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  output logic o_done
);

  localparam logic [LAT_CNT_W-1:0] LOAD_VAL = LAT_CNT_W'(RD_LATENCY - 1);

  logic [LAT_CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - LAT_CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/reg_access_master.sv
// ---------------------------------------------------------------------------
// reg_access_master
// Host-side initiator for the board register-file bus. Converts a valid/ready
// command stream (quadlet write, quadlet read, optional block read) into
// sequenced reg_raddr/reg_waddr/reg_wdata/reg_wen cycles and returns read data
// on a valid/ready response stream.
// Configuration macro: REG_BLOCK_READ_EN (defined: cmd_len honoured, block
// reads with address increment; undefined: every read is one quadlet).
// Ports:
//   sysclk, rstn                         clock, async active-low reset
//   cmd_valid/cmd_ready                  command handshake
//   cmd_write, cmd_addr, cmd_wdata       command fields
//   cmd_len                              read quadlet count (0 -> 1, clamped)
//   rsp_valid/rsp_ready                  response handshake
//   rsp_data, rsp_last                   read data, final-quadlet flag
//   reg_raddr, reg_rdata                 register read port
//   reg_waddr, reg_wdata, reg_wen        register write port
//   busy                                 high whenever not IDLE
// ---------------------------------------------------------------------------
module reg_access_master
  import reg_access_master_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LEN    = MAX_LEN_DEF
) (
  input  logic              sysclk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [4:0]        cmd_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] reg_raddr,
  output logic [ADDR_W-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wen,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_rsp_hs;
  logic                w_last;
  logic                w_lat_done;
  logic [ADDR_W-1:0]   r_raddr;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsp_data;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_rsp_hs = rsp_ready && (r_state == ST_RESP);

`ifdef REG_BLOCK_READ_EN
  localparam int CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  // Quadlets still to be read after the one currently in flight.
  logic [CNT_W-1:0] r_remain;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      r_remain <= '0;
    end else if (w_accept && !cmd_write) begin
      r_remain <= CNT_W'(clamp_len(int'(cmd_len), MAX_LEN) - 1);
    end else if (w_rsp_hs && !w_last) begin
      r_remain <= r_remain - CNT_W'(1);
    end
  end

  assign w_last = (r_remain == '0);
`else
  // Single-quadlet reads only: the length field has no effect.
  logic w_unused_len;
  assign w_unused_len = ^cmd_len;
  assign w_last       = 1'b1;
`endif

  reg_rd_delay #(
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_delay (
    .clk    (sysclk),
    .rst_n  (rstn),
    .i_load (r_state == ST_RD_ADDR),
    .o_done (w_lat_done)
  );

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: next-state is assigned a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (cmd_valid) w_next = cmd_write ? ST_WRITE : ST_RD_ADDR;
      ST_WRITE:   w_next = ST_GAP;
      ST_GAP:     w_next = ST_IDLE;
      ST_RD_ADDR: w_next = ST_RD_WAIT;
      ST_RD_WAIT: if (w_lat_done) w_next = ST_RESP;
      ST_RESP:    if (rsp_ready) w_next = w_last ? ST_IDLE : ST_RD_ADDR;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      r_raddr    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept && cmd_write) begin
        r_waddr <= cmd_addr;
        r_wdata <= cmd_wdata;
      end
      if (w_accept && !cmd_write) begin
        r_raddr <= cmd_addr;
      end
`ifdef REG_BLOCK_READ_EN
      else if (w_rsp_hs && !w_last) begin
        r_raddr <= r_raddr + ADDR_W'(1);  // wraps at the top of the space
      end
`endif
      // The address has been stable for RD_LATENCY cycles at this point.
      if (r_state == ST_RD_WAIT && w_lat_done) begin
        r_rsp_data <= reg_rdata;
      end
    end
  end

  // Strobes decode straight from the state register: reg_wen is high only in
  // WRITE, and GAP forces a low cycle before the next write can start.
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign reg_wen   = (r_state == ST_WRITE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_last  = rsp_valid && w_last;
  assign rsp_data  = r_rsp_data;
  assign reg_raddr = r_raddr;
  assign reg_waddr = r_waddr;
  assign reg_wdata = r_wdata;

endmodule

// File: doc/reg_access_master.md
# reg_access_master

Host-side initiator for the board register-file bus: it turns a valid/ready command stream (quadlet write, quadlet read, optional block read) into correctly sequenced `reg_raddr`/`reg_waddr`/`reg_wdata`/`reg_wen` cycles and returns read data on a valid/ready response stream. It sits between the packet front-ends (FireWire/Ethernet command decode, local test sequencers) and the register-file responders (board, channel, PROM, DOUT), so that front-ends do not each re-implement bus timing and `reg_wen` pulse rules.

## Interface
- `ADDR_W`, 16, register address width.
- `DATA_W`, 32, register data width.
- `RD_LATENCY`, 1, number of cycles from `reg_raddr` presented to `reg_rdata` valid; range 1–4.
- `MAX_LEN`, 16, maximum quadlets per block read.

- `sysclk`  in  1  system clock (49.152 MHz).
- `rstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_write`  in  1  1 = quadlet write, 0 = read.
- `cmd_addr`  in  ADDR_W  start address.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_len`  in  5  read quadlet count; 0 is treated as 1; values above MAX_LEN are clamped to MAX_LEN.
- `rsp_valid`  out  1  read data present.
- `rsp_ready`  in  1  consumer accepts read data.
- `rsp_data`  out  DATA_W  read data.
- `rsp_last`  out  1  final quadlet of the current read command.
- `reg_raddr`  out  ADDR_W  register read address.
- `reg_waddr`  out  ADDR_W  register write address.
- `reg_wdata`  out  DATA_W  register write data.
- `reg_wen`  out  1  write strobe, exactly 1 cycle.
- `reg_rdata`  in  DATA_W  register read data.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, WRITE, GAP, RD_ADDR, RD_WAIT, RESP.
- `cmd_ready` is high only in IDLE.
- IDLE → WRITE on an accepted write. The address and data are registered.
- WRITE lasts 1 cycle with `reg_wen` = 1, then moves to GAP.
- GAP lasts 1 cycle with `reg_wen` = 0, then returns to IDLE. GAP guarantees a rising edge of `reg_wen` per write, which the watchdog clears on.
- IDLE → RD_ADDR on an accepted read. The following are loaded: `reg_raddr` = `cmd_addr`, and the remaining count from the clamped `cmd_len`.
- RD_ADDR → RD_WAIT, which holds `reg_raddr` stable for RD_LATENCY cycles, then captures `reg_rdata` into `rsp_data`.
- RESP: `rsp_valid` = 1, and `rsp_data`/`rsp_last` are held stable until `rsp_ready`. On the handshake:
  - If the remaining count is 0, go to IDLE.
  - Otherwise increment `reg_raddr` by 1 (16-bit wrap, 0xFFFF → 0x0000), decrement the count, and go to RD_ADDR.
- `reg_wen` is 0 in every state except WRITE; reads never overlap a write strobe.
- `reg_waddr` and `reg_wdata` hold their last values outside WRITE. `reg_raddr` holds its last value outside reads.
- Reset values (including assertion mid-operation):
  - State IDLE.
  - `reg_wen` = 0, `rsp_valid` = 0, `rsp_last` = 0, `busy` = 0.
  - `reg_raddr`, `reg_waddr`, `reg_wdata`, `rsp_data` = 0.
  - Any in-flight response is dropped.
- `cmd_*` inputs are ignored outside IDLE.

## Timing
- Write accepted at cycle T:
  - `reg_wen` = 1 in T+1 only.
  - `cmd_ready` = 0 in T+1 and T+2, then 1 in T+3.
  - Back-to-back writes complete at 1 per 3 cycles.
- Read accepted at T:
  - `reg_raddr` is valid from T+1.
  - `reg_rdata` is sampled at the end of cycle T+1+RD_LATENCY.
  - `rsp_valid` rises in T+2+RD_LATENCY.
- Each further block quadlet starts RD_LATENCY+2 cycles after the previous `rsp_ready` handshake.
- `rsp_last` is valid exactly when `rsp_valid` is valid.
- `busy` follows state with no added delay.

## Configuration
- Macro: `REG_BLOCK_READ_EN`.
- Defined: `cmd_len` is honoured as described above.
- Undefined:
  - `cmd_len` is ignored and every read is a single quadlet.
  - `rsp_last` = `rsp_valid`.
  - The count register and address increment logic are not synthesized.

## Structure
- State encodings, RD_LATENCY range, MAX_LEN, and the GAP length constant go in the shared constants header alongside the register address defines.
- One sub-module, `reg_rd_delay`: a loadable down-counter that produces the RD_WAIT → capture strobe for a given RD_LATENCY.
- Everything else is in the top module.

## Test plan
- Write 0x0000_00F0 to address 0x0000 → `reg_wen` high for exactly 1 cycle, `reg_waddr` = 0x0000, `reg_wdata` = 0x0000_00F0; `cmd_ready` returns 2 cycles later.
- Three back-to-back writes with `cmd_valid` held high → three distinct `reg_wen` pulses, each separated by ≥1 low cycle; 9 cycles total.
- Read of 0x0004 with a responder returning 0x0400_1234 after RD_LATENCY = 1 → `rsp_valid` at T+3, `rsp_data` = 0x0400_1234, `rsp_last` = 1.
- Block read, `cmd_addr` = 0xFFFE, `cmd_len` = 3, `rsp_ready` low for 5 cycles on quadlet 2 → addresses 0xFFFE, 0xFFFF, 0x0000; data is held stable during the stall; `rsp_last` only on the third; without `REG_BLOCK_READ_EN` only 0xFFFE is read and `rsp_last` = 1.
- `cmd_len` = 0 → one quadlet; `cmd_len` = 31 → 16 quadlets (with the macro defined).
- `rstn` asserted during RD_WAIT of a block read → outputs immediately at reset values; after release, `cmd_ready` = 1 and no stale `rsp_valid` appears.
